// File: rtl/red_mc_unit.sv
// Multi-cycle RED responder: serially sums the four signed bytes of rs and rt
// and returns the sign-extended result through a valid/ready handshake.
module red_mc_unit #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      rs,
    input  logic [15:0]      rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  cnt;
    logic [15:0] rs_q;
    logic [15:0] rt_q;
    logic [9:0]  acc;
    logic [9:0]  sum;
    logic [9:0]  res;
    logic [7:0]  cur_byte;
    logic        accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = ACC;
                end
            end
            ACC: begin
                if (cnt == 2'd3) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Byte order: rs low, rs high, rt low, rt high
    always_comb begin
        cur_byte = 8'h00;
        case (cnt)
            2'd0:    cur_byte = rs_q[7:0];
            2'd1:    cur_byte = rs_q[15:8];
            2'd2:    cur_byte = rt_q[7:0];
            default: cur_byte = rt_q[15:8];
        endcase
    end

    assign sum = acc + {{2{cur_byte[7]}}, cur_byte};

    // res holds the last completed result so rd survives handshakes and flushes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            acc  <= 10'd0;
            rs_q <= 16'h0000;
            rt_q <= 16'h0000;
            res  <= 10'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else if (accept) begin
            rs_q <= rs;
            rt_q <= rt;
            acc  <= 10'd0;
            cnt  <= 2'd0;
        end else if (state == ACC) begin
            acc <= sum;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                res <= sum;
            end
        end
    end

    assign rd = OUT_W'($signed(res));

endmodule

// File: tb/tb_red_mc_unit.sv
// Directed, table-driven bench for red_mc_unit: back-to-back requests,
// extremes, back-pressure, flush and reset corner cases.
module tb_red_mc_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] rs;
    logic [15:0] rt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] rd;

    int applied;
    int miscompares;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    red_mc_unit #(.OUT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request at the current negedge and complete it with out_ready=1.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] exp_rd, input string name);
        int cycles;
        int low_ready;
        check_output({name, "_in_ready_before"}, 16'(in_ready), 16'd1);
        rs        = a;
        rt        = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        rs        = 16'hA5A5;
        rt        = 16'h5A5A;
        cycles    = 0;
        low_ready = 0;
        if (!in_ready) low_ready++;
        while (!out_valid && cycles < 10) begin
            step();
            cycles++;
            if (!in_ready) low_ready++;
        end
        check_output({name, "_latency"}, 16'(cycles), 16'd4);
        check_output({name, "_in_ready_low"}, 16'(low_ready), 16'd5);
        check_output({name, "_rd"}, rd, exp_rd);
        step();
        check_output({name, "_valid_after_hs"}, 16'(out_valid), 16'd0);
        check_output({name, "_rd_kept"}, rd, exp_rd);
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        rs          = 16'h0000;
        rt          = 16'h0000;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFC};
        vecs[1] = '{16'h0101, 16'h1234, 16'h0048};
        vecs[2] = '{16'h007F, 16'h7F00, 16'h00FE};
        vecs[3] = '{16'hE300, 16'h00E5, 16'hFFC8};
        vecs[4] = '{16'hFF00, 16'hF200, 16'hFFF1};
        vecs[5] = '{16'h8080, 16'h8080, 16'hFE00};
        vecs[6] = '{16'h7F7F, 16'h7F7F, 16'h01FC};
        vecs[7] = '{16'h0000, 16'h0001, 16'h0001};

        @(negedge clk);
        step();
        check_output("reset_in_ready", 16'(in_ready), 16'd1);
        check_output("reset_out_valid", 16'(out_valid), 16'd0);
        check_output("reset_rd", rd, 16'h0000);
        rst_n = 1'b1;
        step();

        // Back-to-back: each call re-enters from IDLE one cycle after handshake
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].rs, vecs[i].rt, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Back-pressure held for 10 cycles with a stray request
        rs        = 16'h0101;
        rt        = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_output("bp_valid_start", 16'(out_valid), 16'd1);
        rs       = 16'h7F7F;
        rt       = 16'h7F7F;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_output($sformatf("bp_valid_%0d", i), 16'(out_valid), 16'd1);
            check_output($sformatf("bp_rd_%0d", i), rd, 16'h0048);
            check_output($sformatf("bp_in_ready_%0d", i), 16'(in_ready), 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_output("bp_release_valid", 16'(out_valid), 16'd0);
        check_output("bp_release_in_ready", 16'(in_ready), 16'd1);

        // Flush in the second ACC cycle
        rs       = 16'h0101;
        rt       = 16'h1234;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_output("flush_in_ready", 16'(in_ready), 16'd1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (out_valid) seen++;
                step();
            end
            check_output("flush_no_valid", 16'(seen), 16'd0);
        end
        apply_stimulus(16'h007F, 16'h7F00, 16'h00FE, "after_flush");

        // Flush together with in_valid in IDLE
        rs       = 16'h0101;
        rt       = 16'h1234;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_output("flush_accept_in_ready", 16'(in_ready), 16'd1);
        for (int i = 0; i < 5; i++) step();
        check_output("flush_accept_no_valid", 16'(out_valid), 16'd0);

        // Reset while holding a result in DONE
        rs        = 16'h0101;
        rt        = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_output("rst_done_valid_pre", 16'(out_valid), 16'd1);
        rst_n = 1'b0;
        step();
        check_output("rst_done_valid", 16'(out_valid), 16'd0);
        check_output("rst_done_rd", rd, 16'h0000);
        check_output("rst_done_in_ready", 16'(in_ready), 16'd1);

        // Reset held low with in_valid high must not accept
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        check_output("rst_hold_in_ready", 16'(in_ready), 16'd1);
        for (int i = 0; i < 5; i++) step();
        check_output("rst_hold_no_valid", 16'(out_valid), 16'd0);
        check_output("rst_hold_in_ready_end", 16'(in_ready), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
